cv32e40p_obi_instr_responder: RTL and testbench

// - OBI responder (memory side) for the core instruction fetch port. Accepts read

---
 rtl/cv32e40p_obi_instr_responder.sv | 144 ++++++++++++++
 tb/tb_cv32e40p_obi_instr_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_obi_instr_responder.sv
// OBI instruction-fetch responder: grants reads, accesses a 1-cycle SRAM,
// and returns in-order responses through a small queue.
module cv32e40p_obi_instr_responder #(
  parameter logic [31:0] MEM_BASE = 32'h0000_0000,
  parameter int MEM_WORDS = 16384,
  parameter int MAX_OUTSTANDING = 2,
  localparam int ADDR_W = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              obi_req_i,
  output logic              obi_gnt_o,
  input  logic [31:0]       obi_addr_i,
  input  logic              obi_we_i,
  input  logic [3:0]        obi_be_i,
  input  logic [31:0]       obi_wdata_i,
  output logic              obi_rvalid_o,
  output logic [31:0]       obi_rdata_o,
  output logic              obi_err_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              gnt_stall_i,
  input  logic              rvalid_stall_i
);

  localparam int PTR_W =
    (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [32:0] BASE33 = {1'b0, MEM_BASE};
  localparam logic [32:0] LIMIT33 =
    BASE33 + (33'(MEM_WORDS) << 2);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR =
    PTR_W'(MAX_OUTSTANDING - 1);

  logic [CNT_W-1:0] out_cnt;
  logic             pend_v;
  logic             pend_err;

  logic [31:0]      fifo_data [MAX_OUTSTANDING];
  logic             fifo_err  [MAX_OUTSTANDING];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] fifo_cnt;

  logic        accept;
  logic        in_range;
  logic        ok;
  logic [32:0] addr33;
  logic [31:0] offset;
  logic        push;
  logic        pop;
  logic        empty;
  logic        full;
  logic        unused_ok;

  function automatic logic [PTR_W-1:0] nxt(
    input logic [PTR_W-1:0] p
  );
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign obi_gnt_o = !rst && !gnt_stall_i
                     && (out_cnt < MAX_CNT);
  assign accept    = obi_req_i && obi_gnt_o;

  assign addr33    = {1'b0, obi_addr_i};
  assign in_range  = (addr33 >= BASE33)
                     && (addr33 < LIMIT33);
  assign ok        = in_range && !obi_we_i;
  assign offset    = obi_addr_i - MEM_BASE;

  assign mem_req_o  = accept && ok;
  assign mem_addr_o = offset[ADDR_W+1:2];

  assign unused_ok = ^{obi_be_i, obi_wdata_i, offset};

  assign empty = (fifo_cnt == '0);
  assign full  = (fifo_cnt == MAX_CNT);
  assign push  = pend_v;
  assign pop   = obi_rvalid_o;

  assign obi_rvalid_o = !empty && !rvalid_stall_i;
  assign obi_rdata_o  = empty ? 32'h0 : fifo_data[rd_ptr];
  assign obi_err_o    = empty ? 1'b0 : fifo_err[rd_ptr];

  // Capture stage: SRAM data arrives one cycle after the accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_v   <= 1'b0;
      pend_err <= 1'b0;
    end else begin
      pend_v   <= accept;
      pend_err <= accept && !ok;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt <= '0;
    end else begin
      unique case ({accept, pop})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_data[i] <= 32'h0;
        fifo_err[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= pend_err ? 32'h0 : mem_rdata_i;
        fifo_err[wr_ptr]  <= pend_err;
        wr_ptr            <= nxt(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= nxt(rd_ptr);
      end
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst) !(push && full)
  );
  a_no_underflow: assert property (
    @(posedge clk) disable iff (rst) !(pop && empty)
  );

endmodule

// File: tb/tb_cv32e40p_obi_instr_responder.sv
// Randomized bench for the OBI instruction responder with a
// transaction-level queue model of the expected responses.
module tb_cv32e40p_obi_instr_responder;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int WORDS = 256;
  localparam int MAXO  = 2;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          obi_req_i;
  logic          obi_gnt_o;
  logic [31:0]   obi_addr_i;
  logic          obi_we_i;
  logic [3:0]    obi_be_i;
  logic [31:0]   obi_wdata_i;
  logic          obi_rvalid_o;
  logic [31:0]   obi_rdata_o;
  logic          obi_err_o;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_rdata_i;
  logic          gnt_stall_i;
  logic          rvalid_stall_i;

  cv32e40p_obi_instr_responder #(
    .MEM_BASE(BASE),
    .MEM_WORDS(WORDS),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .obi_req_i(obi_req_i),
    .obi_gnt_o(obi_gnt_o),
    .obi_addr_i(obi_addr_i),
    .obi_we_i(obi_we_i),
    .obi_be_i(obi_be_i),
    .obi_wdata_i(obi_wdata_i),
    .obi_rvalid_o(obi_rvalid_o),
    .obi_rdata_o(obi_rdata_o),
    .obi_err_o(obi_err_o),
    .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_rdata_i(mem_rdata_i),
    .gnt_stall_i(gnt_stall_i),
    .rvalid_stall_i(rvalid_stall_i)
  );

  always #5 clk = ~clk;

  logic [31:0] sram [WORDS];

  always @(posedge clk)
    if (mem_req_o) mem_rdata_i <= sram[mem_addr_o];

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          rdy;
  } rsp_t;

  rsp_t q[$];
  int   cyc;
  int   n_chk;
  int   n_err;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at cycle %0d",
               tag, obs, exp, cyc);
    end
  endtask

  task automatic cycle(input logic req,
                       input logic [31:0] addr,
                       input logic we,
                       input logic gs,
                       input logic rs);
    logic [32:0] a33, lo, hi;
    logic [31:0] off;
    logic        inr, e_gnt, e_mreq, hrdy, e_rv;
    logic [31:0] e_rd;
    logic        e_er;
    rsp_t        r;
    @(negedge clk);
    obi_req_i      = req;
    obi_addr_i     = addr;
    obi_we_i       = we;
    obi_be_i       = 4'($urandom);
    obi_wdata_i    = $urandom;
    gnt_stall_i    = gs;
    rvalid_stall_i = rs;
    #1;
    a33    = {1'b0, addr};
    lo     = {1'b0, BASE};
    hi     = lo + 33'(4 * WORDS);
    inr    = (a33 >= lo) && (a33 < hi);
    off    = addr - BASE;
    e_gnt  = !gs && (q.size() < MAXO);
    e_mreq = req && e_gnt && inr && !we;
    hrdy   = (q.size() > 0) && (q[0].rdy <= cyc);
    e_rv   = hrdy && !rs;
    e_rd   = hrdy ? q[0].data : 32'h0;
    e_er   = hrdy ? q[0].err : 1'b0;
    chk("gnt", 32'(obi_gnt_o), 32'(e_gnt));
    chk("mem_req", 32'(mem_req_o), 32'(e_mreq));
    if (e_mreq)
      chk("mem_addr", 32'(mem_addr_o), 32'(off / 4 % WORDS));
    chk("rvalid", 32'(obi_rvalid_o), 32'(e_rv));
    chk("rdata", obi_rdata_o, e_rd);
    chk("err", 32'(obi_err_o), 32'(e_er));
    @(posedge clk);
    if (e_rv) void'(q.pop_front());
    if (req && e_gnt) begin
      r.err  = !(inr && !we);
      r.data = r.err ? 32'h0 : sram[off / 4 % WORDS];
      r.rdy  = cyc + 2;
      q.push_back(r);
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    obi_req_i = 1'b1;
    #1;
    chk("rst_gnt", 32'(obi_gnt_o), 32'h0);
    chk("rst_rvalid", 32'(obi_rvalid_o), 32'h0);
    chk("rst_rdata", obi_rdata_o, 32'h0);
    chk("rst_err", 32'(obi_err_o), 32'h0);
    chk("rst_mem_req", 32'(mem_req_o), 32'h0);
    q.delete();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    obi_req_i = 1'b0;
    rst       = 1'b0;
    @(posedge clk);
    cyc++;
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k <= 5)
      return BASE + 32'($urandom_range(0, WORDS - 1)) * 4
             + 32'($urandom_range(0, 3));
    else if (k == 6) return BASE + 32'(4 * WORDS);
    else if (k == 7) return BASE + 32'(4 * WORDS - 4);
    else if (k == 8) return $urandom;
    return 32'hFFFF_FFFC;
  endfunction

  initial begin
    logic gs, rs;
    n_chk = 0;
    n_err = 0;
    cyc   = 0;
    for (int i = 0; i < WORDS; i++) sram[i] = $urandom;
    sram[4] = 32'hDEAD_BEEF;
    mem_rdata_i    = 32'h0;
    rst            = 1'b1;
    obi_req_i      = 1'b0;
    obi_addr_i     = 32'h0;
    obi_we_i       = 1'b0;
    obi_be_i       = 4'h0;
    obi_wdata_i    = 32'h0;
    gnt_stall_i    = 1'b0;
    rvalid_stall_i = 1'b0;
    do_reset();

    cycle(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++)
      cycle(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++)
      cycle(1'b1, 32'(i * 4), 1'b0, 1'b0, (i >= 2 && i < 7));
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    cycle(1'b1, BASE + 32'(4 * WORDS), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++)
      cycle(1'b1, 32'(i * 4), 1'b0, i[0], 1'b0);

    cycle(1'b1, 32'h20, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h24, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h28, 1'b0, 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    gs = 1'b0;
    rs = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) gs = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) rs = ($urandom_range(0, 2) == 0);
      if (i % 700 == 350) do_reset();
      cycle($urandom_range(0, 3) != 0, rand_addr(),
            $urandom_range(0, 9) == 0, gs, rs);
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("drained", 32'(q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
